// File: rtl/me_pkg.sv
// Shared defaults and layout helpers for the motion-estimation reference skew buffer.
// The stage storage of all candidates is packed into one chain; helpers give widths and offsets.
package me_pkg;

   localparam int PIX_W_DEF    = 8;
   localparam int BLK_W_DEF    = 16;
   localparam int NUM_CAND_DEF = 8;
   localparam int WIN_W_DEF    = PIX_W_DEF * BLK_W_DEF;

   function automatic int win_width(input int pix_w, input int blk_w);
      return pix_w * blk_w;
   endfunction

   // Stage i keeps in_pix-i pixels, so stage k starts after the sum of all earlier stages.
   function automatic int store_off(input int k, input int in_pix, input int pix_w);
      return pix_w * (k * in_pix - (k * (k - 1)) / 2);
   endfunction

endpackage

// File: rtl/me_skew_stage.sv
// One skew stage: registers the pixels still needed by this candidate and all later ones,
// together with the valid/last flags of the beat it carries.
module me_skew_stage import me_pkg::*; #(
   parameter int STAGE    = 0,
   parameter int PIX_W    = PIX_W_DEF,
   parameter int BLK_W    = BLK_W_DEF,
   parameter int NUM_CAND = NUM_CAND_DEF,
   localparam int STORE_W = (BLK_W + NUM_CAND - 1 - STAGE) * PIX_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic               last_i,
   input  logic [STORE_W-1:0] data_i,
   output logic               valid_o,
   output logic               last_o,
   output logic [STORE_W-1:0] store_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         store_o <= '0;
      end else begin
         // Flush wins over enable so the flags clear even while the pipe is frozen.
         if (flush_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end else if (en_i) begin
            valid_o <= valid_i;
            last_o  <= valid_i & last_i;
         end
         if (en_i && valid_i) begin
            store_o <= data_i;
         end
      end
   end

endmodule

// File: rtl/me_ref_skew_buf.sv
// Reference-pixel skew buffer: candidate k shows pixels k..k+BLK_W-1 of a beat, k cycles
// after candidate 0, each stage dropping the one pixel no later candidate needs.
module me_ref_skew_buf import me_pkg::*; #(
   parameter int PIX_W    = PIX_W_DEF,
   parameter int BLK_W    = BLK_W_DEF,
   parameter int NUM_CAND = NUM_CAND_DEF
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  en_i,
   input  logic                                  flush_i,
   input  logic                                  in_valid_i,
   input  logic                                  in_last_i,
   input  logic [(BLK_W+NUM_CAND-1)*PIX_W-1:0]   data_i,
   output logic [NUM_CAND*BLK_W*PIX_W-1:0]       win_o,
   output logic [NUM_CAND-1:0]                   win_valid_o,
   output logic [NUM_CAND-1:0]                   win_last_o
);

   localparam int IN_PIX  = BLK_W + NUM_CAND - 1;
   localparam int WIN_W   = win_width(PIX_W, BLK_W);
   localparam int CHAIN_W = store_off(NUM_CAND, IN_PIX, PIX_W);

   logic [CHAIN_W-1:0]  chain;
   logic [NUM_CAND-1:0] valid_q;
   logic [NUM_CAND-1:0] last_q;

   for (genvar k = 0; k < NUM_CAND; k++) begin : g_stage
      localparam int OFF = store_off(k, IN_PIX, PIX_W);
      localparam int SW  = (IN_PIX - k) * PIX_W;

      logic [SW-1:0] d_in;
      logic          v_in;
      logic          l_in;

      if (k == 0) begin : g_head
         assign d_in = data_i;
         assign v_in = in_valid_i;
         assign l_in = in_last_i;
      end else begin : g_tail
         localparam int PREV = store_off(k - 1, IN_PIX, PIX_W);
         // Pixel k-1 is consumed by candidate k-1 only, so it is not carried further.
         assign d_in = chain[PREV + PIX_W +: SW];
         assign v_in = valid_q[k-1];
         assign l_in = last_q[k-1];
      end

      me_skew_stage #(
         .STAGE    (k),
         .PIX_W    (PIX_W),
         .BLK_W    (BLK_W),
         .NUM_CAND (NUM_CAND)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .en_i    (en_i),
         .flush_i (flush_i),
         .valid_i (v_in),
         .last_i  (l_in),
         .data_i  (d_in),
         .valid_o (valid_q[k]),
         .last_o  (last_q[k]),
         .store_o (chain[OFF +: SW])
      );

      assign win_o[k*WIN_W +: WIN_W] = chain[OFF +: WIN_W];
   end

   assign win_valid_o = valid_q;
   assign win_last_o  = last_q;

endmodule

// File: tb/tb_me_ref_skew_buf.sv
// Bench for me_ref_skew_buf: a pixel-pattern scoreboard keyed on enabled clock edges,
// a per-cycle valid/last table for a single beat, and directed freeze/flush/reset sequences.
module tb_me_ref_skew_buf;

   localparam int PIX_W    = 8;
   localparam int BLK_W    = 16;
   localparam int NUM_CAND = 8;
   localparam int IN_PIX   = BLK_W + NUM_CAND - 1;
   localparam int WIN_W    = PIX_W * BLK_W;

   logic                          clk_i = 1'b0;
   logic                          rst_i;
   logic                          en_i;
   logic                          flush_i;
   logic                          in_valid_i;
   logic                          in_last_i;
   logic [IN_PIX*PIX_W-1:0]       data_i;
   logic [NUM_CAND*WIN_W-1:0]     win_o;
   logic [NUM_CAND-1:0]           win_valid_o;
   logic [NUM_CAND-1:0]           win_last_o;

   me_ref_skew_buf #(.PIX_W(PIX_W), .BLK_W(BLK_W), .NUM_CAND(NUM_CAND)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_last_i   (in_last_i),
      .data_i      (data_i),
      .win_o       (win_o),
      .win_valid_o (win_valid_o),
      .win_last_o  (win_last_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected appearance of beat b on candidate k while the enabled-edge count equals due.
   typedef struct {
      int k;
      int due;
      int b;
      bit lst;
   } exp_t;

   exp_t exp_q[$];
   int   tick = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   typedef struct {
      bit                  en;
      bit                  v;
      bit                  l;
      bit                  fl;
      logic [NUM_CAND-1:0] exp_v;
      logic [NUM_CAND-1:0] exp_l;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [PIX_W-1:0] pix(input int b, input int j);
      return PIX_W'((b * 32 + j) % 256);
   endfunction

   function automatic logic [IN_PIX*PIX_W-1:0] beat_data(input int b);
      logic [IN_PIX*PIX_W-1:0] d;
      for (int j = 0; j < IN_PIX; j++) d[j*PIX_W +: PIX_W] = pix(b, j);
      return d;
   endfunction

   function automatic logic [WIN_W-1:0] exp_win(input int b, input int k);
      logic [WIN_W-1:0] w;
      for (int j = 0; j < BLK_W; j++) w[j*PIX_W +: PIX_W] = pix(b, k + j);
      return w;
   endfunction

   task automatic check(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, WIN_W'(win_valid_o), '0);
      check({tag, "_last"}, WIN_W'(win_last_o), '0);
      for (int k = 0; k < NUM_CAND; k++)
         check($sformatf("%s_win%0d", tag, k), win_o[k*WIN_W +: WIN_W], '0);
   endtask

   // Retire beats that have moved on, then compare every candidate against what is due now.
   task automatic sample();
      logic [NUM_CAND-1:0] ev;
      logic [NUM_CAND-1:0] el;
      int                  eb[NUM_CAND];
      ev = '0;
      el = '0;
      for (int k = 0; k < NUM_CAND; k++) eb[k] = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
         if (exp_q[i].due < tick) exp_q.delete(i);
      foreach (exp_q[i]) begin
         if (exp_q[i].due == tick) begin
            ev[exp_q[i].k] = 1'b1;
            el[exp_q[i].k] = exp_q[i].lst;
            eb[exp_q[i].k] = exp_q[i].b;
         end
      end
      check("sb_valid", WIN_W'(win_valid_o), WIN_W'(ev));
      check("sb_last", WIN_W'(win_last_o), WIN_W'(el));
      for (int k = 0; k < NUM_CAND; k++)
         if (ev[k]) check($sformatf("sb_win%0d_b%0d", k, eb[k]), win_o[k*WIN_W +: WIN_W], exp_win(eb[k], k));
   endtask

   // Called at a falling edge: drive, take one rising edge, update the model, sample.
   task automatic step(input bit en, input bit v, input bit l, input bit fl, input int b);
      en_i       = en;
      in_valid_i = v;
      in_last_i  = l;
      flush_i    = fl;
      if (v) begin
         data_i = beat_data(b);
      end else begin
         for (int j = 0; j < IN_PIX; j++) data_i[j*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
      end
      @(posedge clk_i);
      if (fl) begin
         exp_q.delete();
         if (en) tick++;
      end else if (en) begin
         tick++;
         if (v) for (int k = 0; k < NUM_CAND; k++) exp_q.push_back('{k, tick + k, b, l});
      end
      @(negedge clk_i);
      sample();
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_i = 1'b0;
      #1 check_zero(tag);
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt[NUM_CAND];

      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01};
      for (int i = 1; i < NUM_CAND; i++)
         tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, NUM_CAND'(1 << i), NUM_CAND'(1 << i)};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

      rst_i = 1'b0; en_i = 1'b0; flush_i = 1'b0;
      in_valid_i = 1'b0; in_last_i = 1'b0; data_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_zero("reset");
      rst_i = 1'b1;

      // Single beat 0 carrying last, followed by bubbles.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].en, tbl[i].v, tbl[i].l, tbl[i].fl, 0);
         check($sformatf("tbl%0d_valid", i), WIN_W'(win_valid_o), WIN_W'(tbl[i].exp_v));
         check($sformatf("tbl%0d_last", i), WIN_W'(win_last_o), WIN_W'(tbl[i].exp_l));
      end

      // Twenty back-to-back beats: each candidate valid for exactly twenty cycles.
      for (int k = 0; k < NUM_CAND; k++) cnt[k] = 0;
      for (int i = 0; i < 29; i++) begin
         if (i < 20) step(1'b1, 1'b1, 1'b0, 1'b0, i);
         else        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
         for (int k = 0; k < NUM_CAND; k++) cnt[k] += int'(win_valid_o[k]);
      end
      for (int k = 0; k < NUM_CAND; k++) check($sformatf("b2b_cnt%0d", k), WIN_W'(cnt[k]), WIN_W'(20));

      // Freeze three cycles after beat 2; offered beats during the freeze are ignored.
      for (int b = 0; b < 3; b++) step(1'b1, 1'b1, 1'b0, 1'b0, b);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 99);
      for (int b = 3; b < 5; b++) step(1'b1, 1'b1, b == 4, 1'b0, b);
      bubbles(9);

      // Flush coincident with beat 4: nothing in flight survives, beat 5 restarts cleanly.
      for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 1'b0, 1'b0, b);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4);
      check("flush_valid", WIN_W'(win_valid_o), '0);
      check("flush_last", WIN_W'(win_last_o), '0);
      for (int b = 5; b < 8; b++) step(1'b1, 1'b1, b == 7, 1'b0, b);
      bubbles(9);

      // Flush while frozen still clears the flags.
      for (int b = 0; b < 3; b++) step(1'b1, 1'b1, 1'b1, 1'b0, b);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      check("flush_frozen_valid", WIN_W'(win_valid_o), '0);
      bubbles(9);

      // Asynchronous reset mid-stream.
      for (int b = 0; b < 6; b++) step(1'b1, 1'b1, b[0], 1'b0, b);
      async_reset("midrst");
      bubbles(9);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) == 0, 40 + i);
         if (i == 150) async_reset("rndrst");
      end
      bubbles(9);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
